// File: rtl/sdf_arbiter.sv
// sdf_arbiter: round-robin arbiter sharing one SDF evaluator among ray-march requesters,
// with a bounded wait that substitutes a max-distance miss on evaluator timeout.
module sdf_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BITS    = 32,
    parameter int TIMEOUT = 1024,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*BITS-1:0] req_x,
    input  logic [NUM_REQ*BITS-1:0] req_y,
    input  logic [NUM_REQ*BITS-1:0] req_z,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [BITS-1:0]         resp_dist,
    output logic                    resp_timeout,
    output logic                    sdf_start,
    output logic [BITS-1:0]         sdf_x,
    output logic [BITS-1:0]         sdf_y,
    output logic [BITS-1:0]         sdf_z,
    input  logic                    sdf_done,
    input  logic [BITS-1:0]         sdf_out,
    output logic                    busy,
    output logic [IW-1:0]           grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel;
    logic [IW:0] cand;
    logic [CW-1:0] cnt;
    logic any_req;
    // Scan from the farthest offset inward so the nearest valid index after rr_ptr wins.
    always_comb begin
        sel = rr_ptr;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            cand = cand >= (IW+1)'(NUM_REQ) ? cand - (IW+1)'(NUM_REQ) : cand;
            sel = req_valid[cand[IW-1:0]] ? cand[IW-1:0] : sel;
        end
    end
    assign any_req = |req_valid;
    assign req_ready = (state == IDLE && any_req) ? NUM_REQ'(1) << sel : '0;
    assign busy = state != IDLE;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_id <= '0;
            sdf_start <= 1'b0;
            resp_valid <= '0;
            resp_dist <= '0;
            resp_timeout <= 1'b0;
            sdf_x <= '0;
            sdf_y <= '0;
            sdf_z <= '0;
            cnt <= '0;
        end else begin
            sdf_start <= 1'b0;
            resp_valid <= '0;
            case (state)
                IDLE: if (any_req) begin
                    sdf_x <= req_x[sel*BITS +: BITS];
                    sdf_y <= req_y[sel*BITS +: BITS];
                    sdf_z <= req_z[sel*BITS +: BITS];
                    grant_id <= sel;
                    sdf_start <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    cnt <= '0;
                    state <= WAIT;
                end
                // A completion on the final wait cycle still beats the timeout.
                WAIT: if (sdf_done || cnt == CW'(TIMEOUT - 1)) begin
                    resp_dist <= sdf_done ? sdf_out : {1'b0, {(BITS-1){1'b1}}};
                    resp_timeout <= !sdf_done;
                    resp_valid <= NUM_REQ'(1) << grant_id;
                    state <= RESP;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                RESP: begin
                    rr_ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + IW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdf_arbiter.md
SDF_ARBITER -- requirements
Module: sdf_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (clk_in, rst_in).
REQ-002 Parameter NUM_REQ, default 4, number of ray-march requesters sharing one sdf evaluator.
REQ-003 Parameter BITS, default 32, signed fixed-point width (Q16.16).
REQ-004 Parameter TIMEOUT, default 1024, max WAIT cycles before abandoning an evaluation.
REQ-005 clk_in  input  1  clock, rising edge.
REQ-006 rst_in  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request pending.
REQ-008 req_x, req_y, req_z  input  NUM_REQ*BITS each  packed signed sample point; slice i belongs to requester i.
REQ-009 req_ready  output  NUM_REQ  one-hot acceptance; transfer occurs on req_valid[i] & req_ready[i].
REQ-010 resp_valid  output  NUM_REQ  one-hot, one-cycle result strobe to the owning requester.
REQ-011 resp_dist  output  BITS  signed distance result, valid with resp_valid.
REQ-012 resp_timeout  output  1  result is a timeout substitute, valid with resp_valid.
REQ-013 sdf_start  output  1  one-cycle start pulse to the sdf evaluator.
REQ-014 sdf_x, sdf_y, sdf_z  output  BITS each  point driven to the evaluator.
REQ-015 sdf_done  input  1  evaluator completion strobe.
REQ-016 sdf_out  input  BITS  evaluator distance, valid with sdf_done.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 grant_id  output  $clog2(NUM_REQ)  index of current owner; holds last owner in IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any req_valid, select first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; req_ready is combinational, asserted only for that index, only in IDLE.
REQ-021 On acceptance edge: latch slice coordinates into sdf_x/y/z, latch owner into grant_id, go to ISSUE; no request in IDLE -> stay IDLE, req_ready all zero.
REQ-022 ISSUE: sdf_start=1 for exactly that cycle; clear WAIT counter; go to WAIT.
REQ-023 sdf_x/y/z SHALL stay constant from ISSUE through RESP.
REQ-024 sdf_done SHALL be sampled only in WAIT; asserted in IDLE, ISSUE or RESP it is ignored.
REQ-025 WAIT: on sdf_done, capture sdf_out into resp_dist, resp_timeout<=0, go to RESP; else increment counter.
REQ-026 WAIT: counter reaching TIMEOUT-1 without sdf_done -> resp_dist<=0x7FFFFFFF (max positive, treated as miss), resp_timeout<=1, go to RESP; sdf_done on that same cycle wins over timeout.
REQ-027 RESP: resp_valid[grant_id]=1 for one cycle; rr_ptr<=(grant_id+1) mod NUM_REQ; go to IDLE.
REQ-028 Latency: accept edge at cycle 0 -> sdf_start cycle 1 -> sdf_done earliest cycle 2 -> resp_valid cycle 3 -> next acceptance earliest cycle 4.
REQ-029 A requester still asserting req_valid in IDLE after its response SHALL be treated as a new request subject to round-robin.
REQ-030 req_valid deasserted before acceptance SHALL leave no state; no request is queued.
REQ-031 resp_dist and resp_timeout SHALL hold their values until the next RESP.

Reset
REQ-032 On rst_in: state=IDLE, rr_ptr=0, grant_id=0, sdf_start=0, resp_valid=0, resp_dist=0, resp_timeout=0, sdf_x/y/z=0, counter=0, busy=0.
REQ-033 Reset mid-operation SHALL discard the in-flight request without resp_valid; a later stale sdf_done is ignored per REQ-024.

Verification
REQ-034 Requester 1 sends (0x00010000,0x00020000,0x00030000); model returns 0x00008000 five cycles after start -> one req_ready[1] pulse, one sdf_start with those coords, resp_valid[1] with 0x00008000, timeout 0.
REQ-035 All four req_valid held high from reset, model done 2 cycles after start -> grants 0,1,2,3,0 in order, every response 4 cycles after acceptance, no overlap.
REQ-036 Owner 0 finishes (rr_ptr=1), requesters 0 and 2 valid -> requester 2 granted first, then 0.
REQ-037 TIMEOUT=16, model never asserts done -> resp_valid to owner after 16 WAIT cycles, resp_dist=0x7FFFFFFF, resp_timeout=1, then IDLE.
REQ-038 rst_in pulsed during WAIT, sdf_done pulsed 3 cycles later -> all outputs at reset values, no resp_valid, state stays IDLE.
REQ-039 sdf_done forced high during ISSUE only -> ignored, arbiter waits for the real done in WAIT.
